// File: rtl/uart_tx_arbiter_if.sv
// Purpose : handshake bundle between byte producers, the UART TX arbiter and the transmitter.
// Latency : none (wires only).
// Backpressure: req_ready pulses one-hot per accepted byte; tx_busy from the transmitter holds off grants.
//
// Signals:
//   req_valid [NUM_REQ]       per-requester byte-pending flags
//   req_data  [NUM_REQ*SIZE]  requester i byte at [i*SIZE +: SIZE]
//   req_ready [NUM_REQ]       one-hot, one-cycle accept pulse
//   tx_busy                   transmitter busy flag
//   tx_en                     one-cycle transmit start pulse
//   tx_data   [SIZE]          byte presented to the transmitter
//   grant_id                  index of the last granted requester
//   active                    arbiter not idle
//   wdog_err                  watchdog expiry pulse
// Modports: master = producers/transmitter side, slave = arbiter.
interface uart_tx_arbiter_if #(
    parameter int SIZE    = 8,
    parameter int NUM_REQ = 4
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    tx_busy;
    logic                    tx_en;
    logic [SIZE-1:0]         tx_data;
    logic [GID_W-1:0]        grant_id;
    logic                    active;
    logic                    wdog_err;

    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_en, tx_data, grant_id, active, wdog_err
    );

    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_en, tx_data, grant_id, active, wdog_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Latency : req_valid sampled at edge k -> req_ready in cycle k+1, tx_en in cycle k+2.
// Backpressure: no grant while tx_busy=1 or while a character is in flight (busy must rise and fall).
//
// Ports: clk, rst (async, active-high), bus (uart_tx_arbiter_if.slave).
// Parameters: SIZE (char width), NUM_REQ (2..16), BUSY_TIMEOUT (watchdog cycles).
// Optional macro UART_ARB_WDOG_EN: watchdog on tx_busy never rising after tx_en;
// on expiry wdog_err pulses, the byte is dropped and the FSM returns to IDLE.
module uart_tx_arbiter #(
    parameter int SIZE         = 8,
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state;
    logic [GID_W-1:0]   ptr;
    logic [NUM_REQ-1:0] req_ready_q;
    logic               tx_en_q;
    logic [SIZE-1:0]    tx_data_q;
    logic [GID_W-1:0]   grant_q;
    logic               active_q;
    logic               wdog_q;

`ifdef UART_ARB_WDOG_EN
    localparam int WD_W = $clog2(BUSY_TIMEOUT + 1);
    logic [WD_W-1:0] wdog_cnt;
`endif

    // Per-requester byte view of the flat data bus.
    logic [SIZE-1:0] req_word [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
        assign req_word[g] = bus.req_data[g*SIZE +: SIZE];
    end

    // Round-robin pick: first valid requester at or after ptr+1, wrapping.
    // The last candidate examined is ptr itself, so a lone requester that
    // just won can win again.
    logic [GID_W-1:0] pick;
    logic [GID_W-1:0] cand;
    logic             found;
    always_comb begin
        pick  = ptr;
        cand  = '0;
        found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = GID_W'((int'(ptr) + off) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= GID_W'(NUM_REQ - 1);
            req_ready_q <= '0;
            tx_en_q     <= 1'b0;
            tx_data_q   <= '0;
            grant_q     <= '0;
            active_q    <= 1'b0;
            wdog_q      <= 1'b0;
`ifdef UART_ARB_WDOG_EN
            wdog_cnt    <= '0;
`endif
        end else begin
            req_ready_q <= '0;
            tx_en_q     <= 1'b0;
            wdog_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.tx_busy && found) begin
                        req_ready_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                        tx_data_q   <= req_word[pick];
                        grant_q     <= pick;
                        ptr         <= pick;
                        state       <= LAUNCH;
                        active_q    <= 1'b1;
                    end
                end
                LAUNCH: begin
                    tx_en_q <= 1'b1;
                    state   <= WAIT_BUSY;
`ifdef UART_ARB_WDOG_EN
                    wdog_cnt <= '0;
`endif
                end
                WAIT_BUSY: begin
                    // A busy flag already high (fast or stale) is accepted as the rise.
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end
`ifdef UART_ARB_WDOG_EN
                    else if (wdog_cnt == WD_W'(BUSY_TIMEOUT - 1)) begin
                        // Byte is dropped; ptr keeps the granted index.
                        wdog_q   <= 1'b1;
                        state    <= IDLE;
                        active_q <= 1'b0;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state    <= IDLE;
                        active_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.tx_en     = tx_en_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.grant_id  = grant_q;
    assign bus.active    = active_q;
    assign bus.wdog_err  = wdog_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose : self-checking bench for uart_tx_arbiter with producer, transmitter model and scoreboard.
// Latency : checks req_ready -> tx_en spacing of exactly one cycle.
// Backpressure: transmitter model raises tx_busy after each tx_en; tests also hold tx_busy externally.
module tb_uart_tx_arbiter;
    localparam int SIZE         = 8;
    localparam int NUM_REQ      = 4;
    localparam int BUSY_TIMEOUT = 16;
    localparam int BUSY_LEN     = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_arbiter_if #(.SIZE(SIZE), .NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .SIZE(SIZE), .NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic [7:0] dat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;
    int   tx_cnt   = 0;
    int   rdy_cnt  = 0;
    int   cyc      = 0;
    int   rdy_cyc  = -10;
    logic pending  = 1'b0;

    logic model_busy = 1'b0;
    logic hold_busy  = 1'b0;
    logic model_en   = 1'b1;
    assign bus.tx_busy = model_busy | hold_busy;

    logic [7:0] pbyte [NUM_REQ][4];
    int         phead [NUM_REQ];
    int         ptail [NUM_REQ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (phead[i] < ptail[i]) begin
                bus.req_valid[i]            = 1'b1;
                bus.req_data[i*SIZE +: SIZE] = pbyte[i][phead[i]];
            end else begin
                bus.req_valid[i]            = 1'b0;
                bus.req_data[i*SIZE +: SIZE] = 8'h00;
            end
        end
    endtask

    // Queue a byte at requester id and record the grant expected for it.
    task automatic give(input int id, input logic [7:0] d);
        exp_t e;
        pbyte[id][ptail[id]] = d;
        ptail[id]++;
        e.id  = 2'(id);
        e.dat = d;
        sb.push_back(e);
        refresh();
    endtask

    task automatic wait_tx(input int target, input string name);
        for (int c = 0; c < 300; c++) begin
            if (tx_cnt >= target) break;
            @(negedge clk);
        end
        check(name, tx_cnt, target);
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 300; c++) begin
            if (!bus.active && !model_busy) break;
            @(negedge clk);
        end
        check(name, {bus.active, model_busy}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_tx_en"},     bus.tx_en, 0);
        check({tag, "_tx_data"},   bus.tx_data, 0);
        check({tag, "_grant_id"},  bus.grant_id, 0);
        check({tag, "_active"},    bus.active, 0);
        check({tag, "_wdog_err"},  bus.wdog_err, 0);
    endtask

    // Producers: retire a byte when its accept pulse is seen.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++)
                if (!rst && bus.req_ready[i]) phead[i]++;
            refresh();
        end
    end

    // Transmitter model: busy rises one cycle after tx_en, lasts BUSY_LEN cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.tx_en && model_en) begin
                @(negedge clk);
                model_busy = 1'b1;
                repeat (BUSY_LEN) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (bus.req_ready != '0) begin
                    rdy_cnt++;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_grant actual=%0b expected=none", bus.req_ready);
                    end else begin
                        cur = sb.pop_front();
                        check("grant_onehot", bus.req_ready, 4'b0001 << cur.id);
                        pending = 1'b1;
                        rdy_cyc = cyc;
                    end
                end
                if (bus.tx_en) begin
                    tx_cnt++;
                    check("tx_en_expected", pending, 1);
                    check("tx_en_latency", cyc, rdy_cyc + 1);
                    check("tx_data", bus.tx_data, cur.dat);
                    check("grant_id", bus.grant_id, cur.id);
                    check("tx_en_while_busy", bus.tx_busy, 0);
                    pending = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r0, t0, wc;
        logic seen;
        for (int i = 0; i < NUM_REQ; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
        end
        refresh();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single requester 1.
        give(1, 8'hA5);
        wait_tx(1, "t1_tx_count");
        wait_idle("t1_idle");
        check("t1_tx_data_stable", bus.tx_data, 8'hA5);

        // Fresh reset so requester 0 wins first, then all four contend.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        give(0, 8'h10);
        give(1, 8'h11);
        give(2, 8'h12);
        give(3, 8'h13);
        give(0, 8'h10);
        wait_tx(6, "t2_tx_count");
        wait_idle("t2_idle");

        // External busy holds off grants.
        hold_busy = 1'b1;
        give(0, 8'hC3);
        r0 = rdy_cnt;
        t0 = tx_cnt;
        repeat (10) @(negedge clk);
        check("hold_no_grant", rdy_cnt, r0);
        check("hold_no_tx", tx_cnt, t0);
        hold_busy = 1'b0;
        @(negedge clk);
        check("hold_release_grant", bus.req_ready, 4'b0001);
        wait_tx(7, "t3_tx_count");
        wait_idle("t3_idle");

        // Reset during WAIT_DONE.
        give(2, 8'h77);
        for (int c = 0; c < 50; c++) begin
            if (model_busy) break;
            @(negedge clk);
        end
        check("t4_busy_seen", model_busy, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        pending = 1'b0;
        give(3, 8'h3C);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_tx(9, "t4_tx_count");
        wait_idle("t4_idle");

        // Transmitter never raises busy.
        model_en = 1'b0;
        give(0, 8'h5A);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.tx_en) break;
        end
        check("t5_tx_en_seen", bus.tx_en, 1);
        seen = 1'b0;
        wc   = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.wdog_err && !seen) begin
                seen = 1'b1;
                wc   = c;
            end
        end
`ifdef UART_ARB_WDOG_EN
        check("wdog_delay", wc, BUSY_TIMEOUT);
        check("wdog_back_idle", bus.active, 0);
        model_en = 1'b1;
        give(1, 8'h99);
        wait_tx(11, "t5_resume_tx_count");
        wait_idle("t5_idle");
`else
        check("no_wdog_pulse", seen, 0);
        check("stuck_active", bus.active, 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_en = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmission block between NUM_REQ byte producers.
- Accepts one byte per grant over a valid/ready handshake and drives the transmitter's tx_en/data_in.
- Holds off the next grant until the transmitter's tx_busy has risen and fallen again.
- Sits between on-chip producers (e.g. status/log sources) and the transmission instance.

Parameters:
- SIZE, 8: character width in bits; must match the transmitter's SIZE.
- NUM_REQ, 4: number of requesters; legal range 2..16.
- BUSY_TIMEOUT, 16: cycles to wait for tx_busy to rise after tx_en (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  reset; asynchronous and active-high.
- req_valid  input  NUM_REQ  bit i: requester i holds a byte.
- req_data  input  NUM_REQ*SIZE  requester i byte at bits [i*SIZE +: SIZE].
- req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse; byte is captured in this cycle.
- tx_busy  input  1  busy flag from the transmitter.
- tx_en  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  SIZE  byte to transmitter data_in; registered and stable from accept until the next accept.
- grant_id  output  $clog2(NUM_REQ)  index of the last granted requester.
- active  output  1  high whenever state != IDLE.
- wdog_err  output  1  one-cycle pulse on watchdog expiry.

Behaviour:
- All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If tx_busy=0 and any req_valid=1, pick the first valid requester searching from (ptr+1) mod NUM_REQ upward with wrap.
  - Next cycle: req_ready[i]=1 for exactly one cycle; tx_data, grant_id and ptr load i; go to LAUNCH.
  - If tx_busy=1, no grant is issued regardless of requests.
- LAUNCH: tx_en=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: stay until tx_busy=0, then go to IDLE. A new grant can be made in the IDLE cycle that follows.
- Latency: req_valid sampled at edge k gives req_ready in cycle k+1 and tx_en in cycle k+2.
- Requester rules:
  - A requester holds req_valid and req_data stable until it sees its req_ready pulse.
  - Dropping req_valid before the grant is legal and has no side effect.
  - req_data is sampled only at the arbitration edge.
- Only one requester is granted per transaction. Non-granted requesters are never acknowledged.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0.
- Reset (asynchronous, any state, including mid-character):
  - state=IDLE; req_ready=0, tx_en=0, tx_data=0, grant_id=0, active=0, wdog_err=0.
  - ptr=NUM_REQ-1, so requester 0 wins first.
  - An in-flight byte is not re-issued after reset.
- tx_busy already high in LAUNCH (transmitter fast or stale busy): WAIT_BUSY exits on the first cycle it sees tx_busy=1.

Optional Feature:
- Macro: UART_ARB_WDOG_EN.
- Defined:
  - A counter clears on entry to WAIT_BUSY and increments each cycle while tx_busy=0.
  - If it reaches BUSY_TIMEOUT, wdog_err=1 for one cycle and the FSM returns to IDLE.
  - The byte is dropped, not retried; ptr keeps the granted index.
- Not defined: WAIT_BUSY waits indefinitely; wdog_err is tied to 0; no counter logic is built.

Test Plan:
- Reset, then req_valid=4'b0010 with req_data[15:8]=8'hA5 -> req_ready=4'b0010 for one cycle; tx_en single pulse one cycle later; tx_data=8'hA5. With a transmission/receiver pair looped back, the receiver returns 8'hA5 with rx_done.
- All four requesters valid (bytes 8'h10, 8'h11, 8'h12, 8'h13) -> transmit order 10, 11, 12, 13, 10; exactly one tx_en per byte; no tx_en while tx_busy=1.
- Hold tx_busy=1 externally in IDLE with req_valid=4'b0001 -> no req_ready or tx_en until tx_busy falls; then grant within 1 cycle.
- Assert rst in WAIT_DONE, then release with req_valid=4'b1000 -> all outputs 0 during reset; the next grant goes to requester 3 and the previous byte is not resent.
- With UART_ARB_WDOG_EN defined and BUSY_TIMEOUT=16, tie tx_busy=0 -> wdog_err pulses 16 cycles after entering WAIT_BUSY; FSM returns to IDLE and arbitration resumes. Without the macro: no pulse; active stays 1.
